click_gate_sched: RTL

CLICK_GATE_SCHED -- requirements
Module: click_gate_sched

---
 rtl/click_pkg.sv | 8 +
 rtl/click_sync.sv | 17 +
 rtl/click_gate_sched.sv | 99 +++++++++
 3 files changed

// File: rtl/click_pkg.sv
// click_pkg: shared FSM encoding and default parameters for the click gate scheduler
package click_pkg;
    typedef enum logic [1:0] {IDLE, GRANT, GUARD} state_t;
    localparam int N_DEF = 4;
    localparam int SYNC_STAGES_DEF = 2;
    localparam int GUARD_CYCLES_DEF = 2;
    localparam int CNT_W_DEF = 16;
endpackage

// File: rtl/click_sync.sv
// click_sync: per-bit multi-flop synchronizer for asynchronous phase inputs
module click_sync #(
    parameter int W = 4,
    parameter int STAGES = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);
    logic [STAGES-1:0][W-1:0] r_ff;
    // shift each input bit through STAGES flops
    always_ff @(posedge clk or posedge rst)
        if (rst) r_ff <= '0;
        else r_ff <= {r_ff[STAGES-2:0], i_d};
    assign o_q = r_ff[STAGES-1];
endmodule

// File: rtl/click_gate_sched.sv
// click_gate_sched: round-robin scheduler granting one click_barrier gate at a time
module click_gate_sched
    import click_pkg::*;
#(
    parameter int N = N_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int GUARD_CYCLES = GUARD_CYCLES_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [N-1:0]         req_phase,
    input  logic [N-1:0]         ack_phase,
    output logic [N-1:0]         go,
    output logic [$clog2(N)-1:0] grant_idx,
    output logic                 busy,
    output logic [CNT_W-1:0]     xfer_cnt
);
    localparam int IW = $clog2(N);
    logic [N-1:0] w_req_s, w_ack_s, w_pend;
    logic [N-1:0] r_go;
    logic [IW-1:0] r_idx, r_ptr, w_sel, w_cand;
    logic r_ack_cap, w_found, w_done;
    logic [3:0] r_guard;
    logic [CNT_W-1:0] r_cnt;
    state_t r_state, w_next;

    click_sync #(.W(N), .STAGES(SYNC_STAGES)) u_req_sync (.clk(clk), .rst(rst), .i_d(req_phase), .o_q(w_req_s));
    click_sync #(.W(N), .STAGES(SYNC_STAGES)) u_ack_sync (.clk(clk), .rst(rst), .i_d(ack_phase), .o_q(w_ack_s));

    assign w_pend = w_req_s ^ w_ack_s;
    assign w_done = w_ack_s[r_idx] != r_ack_cap;

    // pick the nearest pending channel after the last grant, wrapping around
    always_comb begin
        w_sel = '0;
        w_cand = '0;
        w_found = 1'b0;
        for (int k = N; k >= 1; k--) begin
            w_cand = IW'((int'(r_ptr) + k) % N);
            if (w_pend[w_cand]) begin
                w_sel = w_cand;
                w_found = 1'b1;
            end
        end
    end

    // state register
    always_ff @(posedge clk or posedge rst)
        if (rst) r_state <= IDLE;
        else r_state <= w_next;

    // next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = (en && w_found) ? GRANT : IDLE;
            GRANT:   w_next = w_done ? ((GUARD_CYCLES == 0) ? IDLE : GUARD) : GRANT;
            GUARD:   w_next = (r_guard <= 4'd1) ? IDLE : GUARD;
            default: w_next = IDLE;
        endcase
    end

    // grant, pointer, ack capture, guard and transfer counter registers
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            r_go <= '0;
            r_idx <= '0;
            r_ptr <= IW'(N - 1);
            r_ack_cap <= 1'b0;
            r_guard <= '0;
            r_cnt <= '0;
        end else begin
            case (r_state)
                IDLE: if (en && w_found) begin
                    r_go <= {{(N-1){1'b0}}, 1'b1} << w_sel;
                    r_idx <= w_sel;
                    r_ptr <= w_sel;
                    r_ack_cap <= w_ack_s[w_sel];
                end
                GRANT: if (w_done) begin
                    r_go <= '0;
                    r_cnt <= r_cnt + 1'b1;
                    r_guard <= 4'(GUARD_CYCLES);
                end
                GUARD: r_guard <= r_guard - 1'b1;
                default: r_go <= '0;
            endcase
        end

    // outputs
    always_comb begin
        go = r_go;
        grant_idx = r_idx;
        busy = r_state != IDLE;
        xfer_cnt = r_cnt;
    end
endmodule
